// File: rtl/register_pipe.sv
// register_pipe: elastic DEPTH-stage register pipeline with valid/ready handshake, flush and bubble collapse.
// Define REGISTER_PIPE_OCCUPANCY_EN to add the registered occupancy counter port.
`timescale 1ns/1ps
module register_pipe #(
   parameter int unsigned           DATA_WIDTH  = 16,
   parameter int unsigned           DEPTH       = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
`ifdef REGISTER_PIPE_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0]      r_v;
   logic [DATA_WIDTH-1:0] r_d [DEPTH];
   logic [DEPTH:0]        w_rdy;
   logic [DEPTH-1:0]      w_src_v;
   logic [DATA_WIDTH-1:0] w_src_d [DEPTH];

   // A stage can take a word if it is empty or everything ahead of it can move,
   // computed as a running OR from the output side to keep the chain acyclic.
   always_comb begin
      logic w_acc;
      w_acc        = out_ready;
      w_rdy        = '0;
      w_rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_acc    = w_acc | ~r_v[i];
         w_rdy[i] = w_acc;
      end
   end

   always_comb begin
      w_src_v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_src_d[i] = in_data;
      end
      w_src_v[0] = in_valid & ~flush;
      for (int i = 1; i < DEPTH; i++) begin
         w_src_v[i] = r_v[i-1];
         w_src_d[i] = r_d[i-1];
      end
   end

   assign in_ready  = w_rdy[0] & ~flush;
   assign out_valid = r_v[DEPTH-1];
   assign out_data  = r_d[DEPTH-1];

   // Data only loads when a valid word arrives, so stalled or drained stages keep their contents.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_v <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_d[i] <= RESET_VALUE;
         end
      end else if (flush) begin
         r_v <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
               r_v[i] <= w_src_v[i];
               if (w_src_v[i]) begin
                  r_d[i] <= w_src_d[i];
               end
            end
         end
      end
   end

`ifdef REGISTER_PIPE_OCCUPANCY_EN
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [OCC_W-1:0] r_occ;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_occ <= '0;
      end else if (flush) begin
         r_occ <= '0;
      end else if (w_in_fire && !w_out_fire) begin
         r_occ <= r_occ + 1'b1;
      end else if (!w_in_fire && w_out_fire) begin
         r_occ <= r_occ - 1'b1;
      end
   end

   assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: randomized and directed bench for register_pipe against a word-level queue model.
// Occupancy is checked only when REGISTER_PIPE_OCCUPANCY_EN is defined.
`timescale 1ns/1ps
module tb_register_pipe;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam logic [DW-1:0] RV  = 16'hC3C3;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
`ifdef REGISTER_PIPE_OCCUPANCY_EN
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

   register_pipe #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .RESET_VALUE(RV)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef REGISTER_PIPE_OCCUPANCY_EN
      ,
      .occupancy(occupancy)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit dut_ifire;

   // Reference: in-flight words in acceptance order, each with the stage it sits in.
   // Each cycle a word advances one stage but never into or past the word ahead.
   logic [DW-1:0] m_data[$];
   int            m_pos[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ov();
      return (m_data.size() != 0) && (m_pos[0] == DEPTH - 1);
   endfunction

   function automatic bit m_in_ready();
      return !flush && ((m_data.size() < DEPTH) || out_ready);
   endfunction

   task automatic m_clear();
      m_data.delete();
      m_pos.delete();
   endtask

   // Inputs are set at the falling edge; check, then let one rising edge pass.
   task automatic cyc();
      bit ofire, ifire;
      int lim, np;
      #1;
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_ov());
      if (m_ov()) chk("out_data", out_data, m_data[0]);
`ifdef REGISTER_PIPE_OCCUPANCY_EN
      chk("occupancy", occupancy, m_data.size());
`endif
      ofire     = m_ov() && out_ready;
      ifire     = in_valid && m_in_ready();
      dut_ifire = in_valid && in_ready;
      @(posedge clk);
      if (ofire) begin
         void'(m_data.pop_front());
         void'(m_pos.pop_front());
      end
      if (flush) begin
         m_clear();
      end else begin
         lim = DEPTH - 1;
         foreach (m_pos[k]) begin
            np       = (m_pos[k] + 1 < lim) ? m_pos[k] + 1 : lim;
            m_pos[k] = np;
            lim      = np - 1;
         end
         if (ifire) begin
            m_data.push_back(in_data);
            m_pos.push_back(0);
         end
      end
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int idx;
      rstn      = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      m_clear();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;

      // Reset state
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, RV);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Single word latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h1234;
      cyc();
      chk("single_accept", dut_ifire, 1);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin cyc(); n++; end
      chk("single_latency", n, 3);
      chk("single_data", out_data, 16'h1234);
      cyc();
      chk("single_one_cycle", out_valid, 0);
      drain();

      // Streaming
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         cyc();
         chk("stream_accept", dut_ifire, 1);
      end
      drain();

      // Backpressure fill
      out_ready = 1'b0;
      idx       = 0;
      in_valid  = 1'b1;
      in_data   = 16'hA001;
      for (int c = 0; c < 8; c++) begin
         cyc();
         if (dut_ifire) idx++;
         in_data = 16'hA001 + 16'(idx);
      end
      chk("fill_accepted", idx, 4);
      #1;
      chk("fill_in_ready", in_ready, 0);
      chk("fill_out_data", out_data, 16'hA001);
`ifdef REGISTER_PIPE_OCCUPANCY_EN
      chk("fill_occupancy", occupancy, 4);
`endif
      @(negedge clk);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && (idx < 5 || m_data.size() != 0); c++) begin
         in_valid = (idx < 5);
         in_data  = 16'hA001 + 16'(idx);
         cyc();
         if (dut_ifire) idx++;
      end
      chk("fill_all_taken", idx, 5);
      drain();

      // Bubble collapse
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0001;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      in_valid = 1'b1;
      in_data  = 16'h0002;
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      chk("bubble_head", out_data, 16'h0001);
`ifdef REGISTER_PIPE_OCCUPANCY_EN
      chk("bubble_occupancy", occupancy, 2);
`endif
      out_ready = 1'b1;
      cyc();
      chk("bubble_next_valid", out_valid, 1);
      chk("bubble_next_data", out_data, 16'h0002);
      drain();

      // Flush with a word offered
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h0100 + 16'(i);
         cyc();
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      #1;
      chk("flush_in_ready", in_ready, 0);
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_out_valid", out_valid, 0);
`ifdef REGISTER_PIPE_OCCUPANCY_EN
      chk("flush_occupancy", occupancy, 0);
`endif
      for (int i = 0; i < DEPTH + 2; i++) begin
         cyc();
         chk("flush_no_beef", out_valid, 0);
      end

      // Asynchronous reset with a full pipe
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h0200 + 16'(i);
         cyc();
      end
      in_valid = 1'b0;
      #3;
      rstn = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, RV);
      chk("arst_in_ready", in_ready, 1);
      m_clear();
      @(negedge clk);
      rstn      = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h5A5A;
      cyc();
      chk("arst_new_accept", dut_ifire, 1);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin cyc(); n++; end
      chk("arst_new_latency", n, 3);
      chk("arst_new_data", out_data, 16'h5A5A);
      drain();

      // Randomized traffic
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         flush     = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = 16'($urandom);
         end
         cyc();
         if (dut_ifire || flush) in_valid = 1'b0;
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
